// File: rtl/gpu_cmd_sequencer.sv
// Opcode front-end: pairs bytes into 16-bit opcodes, queues them, issues gated execute pulses.
// Optional feature macro: SEQ_REPEAT_EN (4'hF opcodes re-issue the last opcode N+1 times).
module gpu_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ISSUE_GAP  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_sync,
    input  logic        core_ready,
    input  logic        clr_ovf,
    output logic [15:0] opcode,
    output logic        execute,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        overflow
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned GapW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

`ifdef SEQ_REPEAT_EN
    typedef enum logic [1:0] {StIdle, StGap, StRepeat} state_e;
`else
    typedef enum logic [1:0] {StIdle, StGap} state_e;
`endif

    state_e            state_q, state_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [15:0]       opcode_q, opcode_d;
    logic              exec_q, exec_d;
`ifdef SEQ_REPEAT_EN
    logic [8:0]        rep_q, rep_d;
`endif

    logic              hi_flag_q;
    logic [7:0]        hi_byte_q;
    logic [15:0]       mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              ovf_q;

    logic              hi_take, pair_done, push_ok, drop, pop;
    logic [15:0]       head;

    // byte_sync overrides the flag, so a byte arriving with it is always a high byte
    assign hi_take   = byte_valid && (byte_sync || hi_flag_q);
    assign pair_done = byte_valid && !byte_sync && !hi_flag_q;

    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push_ok    = pair_done && (!fifo_full || pop);
    assign drop       = pair_done && fifo_full && !pop;
    assign head       = mem_q[rd_ptr_q];

    assign opcode   = opcode_q;
    assign execute  = exec_q;
    assign overflow = ovf_q;

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        opcode_d = opcode_q;
        exec_d   = 1'b0;
        pop      = 1'b0;
`ifdef SEQ_REPEAT_EN
        rep_d    = rep_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && core_ready) begin
                    pop = 1'b1;
`ifdef SEQ_REPEAT_EN
                    if (head[15:12] == 4'hF) begin
                        rep_d   = 9'(head[7:0]) + 9'd1;
                        state_d = StRepeat;
                    end else begin
                        opcode_d = head;
                        exec_d   = 1'b1;
                        gap_d    = '0;
                        state_d  = StGap;
                    end
`else
                    opcode_d = head;
                    exec_d   = 1'b1;
                    gap_d    = '0;
                    state_d  = StGap;
`endif
                end
            end
            StGap: begin
                if (gap_q == GapW'(ISSUE_GAP - 1)) begin
`ifdef SEQ_REPEAT_EN
                    state_d = (rep_q != '0) ? StRepeat : StIdle;
`else
                    state_d = StIdle;
`endif
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
`ifdef SEQ_REPEAT_EN
            StRepeat: begin
                // opcode_q still holds the last issued opcode (0 after reset)
                if (core_ready) begin
                    exec_d  = 1'b1;
                    rep_d   = rep_q - 9'd1;
                    gap_d   = '0;
                    state_d = StGap;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            gap_q    <= '0;
            opcode_q <= '0;
            exec_q   <= 1'b0;
`ifdef SEQ_REPEAT_EN
            rep_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            opcode_q <= opcode_d;
            exec_q   <= exec_d;
`ifdef SEQ_REPEAT_EN
            rep_q    <= rep_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_flag_q <= 1'b1;
            hi_byte_q <= '0;
        end else if (hi_take) begin
            hi_flag_q <= 1'b0;
            hi_byte_q <= byte_in;
        end else if (pair_done || byte_sync) begin
            hi_flag_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {hi_byte_q, byte_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (!push_ok && pop) count_q <= count_q - 1'b1;
            if (drop)         ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// Scoreboard bench for gpu_cmd_sequencer: queue-level reference model, decoupled monitor.
module tb_gpu_cmd_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned GAP   = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_sync = 1'b0;
    logic        core_ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [15:0] opcode;
    logic        execute;
    logic        fifo_full;
    logic        fifo_empty;
    logic        overflow;

    always #5 clk = ~clk;

    gpu_cmd_sequencer #(
        .FIFO_DEPTH(DEPTH),
        .ISSUE_GAP (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_sync (byte_sync),
        .core_ready(core_ready),
        .clr_ovf   (clr_ovf),
        .opcode    (opcode),
        .execute   (execute),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .overflow  (overflow)
    );

    typedef struct {
        logic [15:0] op;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_q[$];
    int          errors = 0;
    int          checks = 0;

    // Reference model state
    bit          m_hi_next = 1'b1;
    logic [7:0]  m_hi = '0;
    logic [15:0] m_last = '0;
    bit          m_ovf = 1'b0;
    int          m_gap = 0;
    int          m_rep = 0;
    int          m_cyc = 0;
    logic [15:0] m_h, m_pair;
    bit          m_have_pair;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, m_cyc);
        end
    endtask

    task automatic model_issue(input logic [15:0] op);
        exp_t e;
        m_last = op;
        e.op   = op;
        e.cyc  = m_cyc;
        exp_q.push_back(e);
        m_gap  = GAP;
    endtask

    always @(posedge clk) begin
        m_cyc++;
        if (!rst_n) begin
            m_hi_next = 1'b1;
            m_hi      = '0;
            m_last    = '0;
            m_ovf     = 1'b0;
            m_gap     = 0;
            m_rep     = 0;
            m_q.delete();
            exp_q.delete();
        end else begin
            if (m_gap > 0) begin
                m_gap--;
            end else if (m_rep > 0) begin
                if (core_ready) begin
                    m_rep--;
                    model_issue(m_last);
                end
            end else if (m_q.size() > 0 && core_ready) begin
                m_h = m_q.pop_front();
`ifdef SEQ_REPEAT_EN
                if (m_h[15:12] == 4'hF) m_rep = int'(m_h[7:0]) + 1;
                else                    model_issue(m_h);
`else
                model_issue(m_h);
`endif
            end
            m_have_pair = 1'b0;
            if (byte_sync) m_hi_next = 1'b1;
            if (byte_valid) begin
                if (m_hi_next) begin
                    m_hi      = byte_in;
                    m_hi_next = 1'b0;
                end else begin
                    m_pair      = {m_hi, byte_in};
                    m_have_pair = 1'b1;
                    m_hi_next   = 1'b1;
                end
            end
            if (m_have_pair && m_q.size() < DEPTH) m_q.push_back(m_pair);
            if (m_have_pair && m_q.size() >= DEPTH && m_q[m_q.size()-1] !== m_pair) m_ovf = 1'b1;
            else if (m_have_pair && m_q.size() >= DEPTH && m_q.size() > DEPTH) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end

    // Monitor: compares the DUT against the model once per cycle, away from the clock edge
    always @(negedge clk) begin
        bit   exp_now;
        exp_t e;
        exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == m_cyc);
        check("execute", {15'd0, execute}, {15'd0, exp_now});
        if (exp_now) begin
            e = exp_q.pop_front();
            check("pulse_opcode", opcode, e.op);
        end
        check("opcode_hold", opcode, m_last);
        check("fifo_empty", {15'd0, fifo_empty}, {15'd0, m_q.size() == 0});
        check("fifo_full", {15'd0, fifo_full}, {15'd0, m_q.size() == DEPTH});
        check("overflow", {15'd0, overflow}, {15'd0, m_ovf});
    end

    task automatic drive(input logic v, input logic [7:0] b, input logic s, input logic r,
                         input logic c);
        byte_valid = v;
        byte_in    = b;
        byte_sync  = s;
        core_ready = r;
        clr_ovf    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        repeat (n) drive(1'b0, 8'h00, 1'b0, r, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single opcode, issued the cycle after the pair completes
        drive(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Overfill with the core stalled, then drain and clear overflow
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
            drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        end
        idle(1, 1'b0);
        check("t2_full", {15'd0, fifo_full}, 16'd1);
        check("t2_ovf", {15'd0, overflow}, 16'd1);
        idle(12, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        check("t2_ovf_clr", {15'd0, overflow}, 16'd0);
        idle(2, 1'b1);

        // Resync discards a dangling high byte; sync with a valid byte takes it as high
        drive(1'b1, 8'h12, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 8'h34, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h56, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h88, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Push into a full FIFO in the exact cycle of an issue
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
            drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        end
        drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b0);
        check("t4_full", {15'd0, fifo_full}, 16'd1);
        check("t4_no_ovf", {15'd0, overflow}, 16'd0);
        idle(12, 1'b1);

        // Reset mid-pair with entries queued
        drive(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h65, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h87, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        check("rst_opcode", opcode, 16'h0000);
        check("rst_empty", {15'd0, fifo_empty}, 16'd1);
        check("rst_exec", {15'd0, execute}, 16'd0);
        drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Repeat opcode (re-issues only when the feature is built in)
        drive(1'b1, 8'h12, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h34, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'hF0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
        idle(16, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) b = {4'h0, b[3:0]};
            drive($urandom_range(0, 99) < 60, b, $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 3);
        end
        idle(2600, 1'b1);

        check("drain_exp", 16'(exp_q.size()), 16'd0);
        check("drain_empty", {15'd0, fifo_empty}, 16'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
